slt_bist: RTL and testbench



---
 rtl/slt_bist_if.sv | 26 ++
 rtl/slt_bist.sv | 183 ++++++++++++++++++
 tb/tb_slt_bist.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/slt_bist_if.sv
// rtl/slt_bist_if.sv - Operand/result and status bus between the SLT BIST and its environment
interface slt_bist_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [15:0]      first_fail_idx;

  // The BIST side drives operands and status, and sees start and the SLT result.
  modport master (
    input  start, Z,
    output X, Y, busy, done, pass, err_count, first_fail_idx
  );

  // The environment side: controller plus the SLT unit under test.
  modport slave (
    output start, Z,
    input  X, Y, busy, done, pass, err_count, first_fail_idx
  );
endinterface

// File: rtl/slt_bist.sv
// rtl/slt_bist.sv - Self-test driver/checker for a signed set-less-than unit
module slt_bist #(
  parameter int          WIDTH      = 32,
  parameter int          NUM_RANDOM = 256,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input logic         clk,
  input logic         rst,
  slt_bist_if.master  bus
);

  typedef enum logic [2:0] {IDLE, DIRECTED, RANDOM, DRAIN, DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is swapped for 1.
  localparam logic [31:0]      SEED_X   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0]      SEED_Y   = (~LFSR_SEED == 32'h0) ? 32'h1 : ~LFSR_SEED;
  localparam logic [15:0]      LAST_IDX = 16'(8 + NUM_RANDOM - 1);
  localparam logic [WIDTH-1:0] V_ZERO   = '0;
  localparam logic [WIDTH-1:0] V_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] V_ONES   = '1;
  localparam logic [WIDTH-1:0] V_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] V_MAX    = ~V_MIN;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic             exp_q, exp_d;
  logic [15:0]      idx_q, idx_d;
  logic [31:0]      lfsr_x_q, lfsr_x_d, lfsr_y_q, lfsr_y_d;
  logic [15:0]      err_q, err_d, ffi_q, ffi_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic             load;
  logic [WIDTH-1:0] nx, ny;

  // Reference signed less-than: sign bits decide when they differ, else the sign of X-Y.
  function automatic logic golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    if (a[WIDTH-1] != b[WIDTH-1]) return a[WIDTH-1];
    return d[WIDTH-1];
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Corner-case operand pairs around zero, sign boundary and all-ones; returns {X, Y}.
  function automatic logic [2*WIDTH-1:0] directed_vec(input logic [2:0] i);
    case (i)
      3'd0:    return {V_ZERO, V_ZERO};
      3'd1:    return {V_ZERO, V_ONE};
      3'd2:    return {V_ONE, V_ZERO};
      3'd3:    return {V_ZERO, V_ONES};
      3'd4:    return {V_ONES, V_ZERO};
      3'd5:    return {V_MIN, V_MAX};
      3'd6:    return {V_MAX, V_MIN};
      default: return {V_ONES - V_ONE, V_ONES};
    endcase
  endfunction

  // Next-state, vector sequencing and result checking.
  always_comb begin
    state_d  = state_q;
    nx       = x_q;
    ny       = y_q;
    load     = 1'b0;
    idx_d    = idx_q;
    lfsr_x_d = lfsr_x_q;
    lfsr_y_d = lfsr_y_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;

    // In DIRECTED/RANDOM the vector on X/Y has settled for a full cycle; score its Z.
    if ((state_q == DIRECTED || state_q == RANDOM) && (bus.Z != exp_q)) begin
      err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      if (ffi_q == 16'hFFFF) ffi_d = idx_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d      = DIRECTED;
          {nx, ny}     = directed_vec(3'd0);
          load         = 1'b1;
          idx_d        = 16'd0;
          lfsr_x_d     = SEED_X;
          lfsr_y_d     = SEED_Y;
          err_d        = 16'd0;
          ffi_d        = 16'hFFFF;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      DIRECTED: begin
        if (idx_q[2:0] == 3'd7) begin
          if (NUM_RANDOM == 0) begin
            state_d = DRAIN;
          end else begin
            state_d  = RANDOM;
            nx       = lfsr_x_q[WIDTH-1:0];
            ny       = lfsr_y_q[WIDTH-1:0];
            load     = 1'b1;
            idx_d    = idx_q + 16'd1;
            lfsr_x_d = lfsr_next(lfsr_x_q);
            lfsr_y_d = lfsr_next(lfsr_y_q);
          end
        end else begin
          {nx, ny} = directed_vec(idx_q[2:0] + 3'd1);
          load     = 1'b1;
          idx_d    = idx_q + 16'd1;
        end
      end
      RANDOM: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          nx       = lfsr_x_q[WIDTH-1:0];
          ny       = lfsr_y_q[WIDTH-1:0];
          load     = 1'b1;
          idx_d    = idx_q + 16'd1;
          lfsr_x_d = lfsr_next(lfsr_x_q);
          lfsr_y_d = lfsr_next(lfsr_y_q);
        end
      end
      DRAIN: begin
        // err_q already includes the last vector, scored on the way into DRAIN.
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 16'd0);
      end
      default: state_d = IDLE;
    endcase

    x_d   = nx;
    y_d   = ny;
    exp_d = load ? golden(nx, ny) : exp_q;
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      exp_q    <= 1'b0;
      idx_q    <= 16'd0;
      lfsr_x_q <= SEED_X;
      lfsr_y_q <= SEED_Y;
      err_q    <= 16'd0;
      ffi_q    <= 16'hFFFF;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      lfsr_x_q <= lfsr_x_d;
      lfsr_y_q <= lfsr_y_d;
      err_q    <= err_d;
      ffi_q    <= ffi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.X              = x_q;
  assign bus.Y              = y_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_slt_bist.sv
// tb/tb_slt_bist.sv - Directed self-checking bench for slt_bist
module tb_slt_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;   // 0: signed SLT, 1: Z stuck at 0, 2: unsigned compare
  int   total = 0;
  int   bad = 0;

  slt_bist_if #(.WIDTH(8))  if0 ();
  slt_bist_if #(.WIDTH(32)) if1 ();

  slt_bist #(.WIDTH(8), .NUM_RANDOM(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  slt_bist dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.Z = (mode == 0) ? ($signed(if0.X) < $signed(if0.Y)) :
                 (mode == 1) ? 1'b0 : (if0.X < if0.Y);
  assign if1.Z = $signed(if1.X) < $signed(if1.Y);

  always #5 clk = ~clk;

  logic [31:0] tx8  [8] = '{32'h00, 32'h00, 32'h01, 32'h00, 32'hFF, 32'h80, 32'h7F, 32'hFE};
  logic [31:0] ty8  [8] = '{32'h00, 32'h01, 32'h00, 32'hFF, 32'h00, 32'h7F, 32'h80, 32'hFF};
  logic [31:0] tx32 [8] = '{32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'h7FFF_FFFF, 32'hFFFF_FFFE};
  logic [31:0] ty32 [8] = '{32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, ".X"}, 32'(if0.X), 32'h0);
    chk({tag, ".Y"}, 32'(if0.Y), 32'h0);
    chk({tag, ".busy"}, 32'(if0.busy), 32'h0);
    chk({tag, ".done"}, 32'(if0.done), 32'h0);
    chk({tag, ".pass"}, 32'(if0.pass), 32'h0);
    chk({tag, ".err"}, 32'(if0.err_count), 32'h0);
    chk({tag, ".ffi"}, 32'(if0.first_fail_idx), 32'hFFFF);
  endtask

  // One NUM_RANDOM=0 run on dut0 with the given Z behaviour.
  task automatic run0(input int m, input bit hold, input logic [15:0] e_err,
                      input logic [15:0] e_ffi, input logic e_pass);
    mode = m;
    @(negedge clk); if0.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) if0.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("run%0d.x%0d", m, i), 32'(if0.X), tx8[i]);
      chk($sformatf("run%0d.y%0d", m, i), 32'(if0.Y), ty8[i]);
      chk($sformatf("run%0d.busy%0d", m, i), 32'(if0.busy), 32'h1);
      @(posedge clk); #1;
    end
    chk("drain.busy", 32'(if0.busy), 32'h1);
    chk("drain.done", 32'(if0.done), 32'h0);
    @(posedge clk); #1;
    chk("end.busy", 32'(if0.busy), 32'h0);
    chk("end.done", 32'(if0.done), 32'h1);
    chk("end.pass", 32'(if0.pass), 32'(e_pass));
    chk("end.err", 32'(if0.err_count), 32'(e_err));
    chk("end.ffi", 32'(if0.first_fail_idx), 32'(e_ffi));
    chk("end.xhold", 32'(if0.X), 32'hFE);
    chk("end.yhold", 32'(if0.Y), 32'hFF);
  endtask

  initial begin
    logic [31:0] lx, ly, ex, ey;
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset0("rst0");
    chk("rst1.busy", 32'(if1.busy), 32'h0);
    chk("rst1.ffi", 32'(if1.first_fail_idx), 32'hFFFF);
    rst = 1'b0;

    run0(0, 1'b0, 16'd0, 16'hFFFF, 1'b1);
    run0(1, 1'b0, 16'd4, 16'd1, 1'b0);
    run0(2, 1'b0, 16'd4, 16'd3, 1'b0);

    // Full directed + 256 random run on the 32-bit instance.
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    lx = 32'h0000_0001;
    ly = 32'hFFFF_FFFE;
    for (int i = 0; i < 264; i++) begin
      if (i < 8) begin
        ex = tx32[i];
        ey = ty32[i];
      end else begin
        ex = lx;
        ey = ly;
        lx = {lx[30:0], lx[31] ^ lx[21] ^ lx[1] ^ lx[0]};
        ly = {ly[30:0], ly[31] ^ ly[21] ^ ly[1] ^ ly[0]};
      end
      chk($sformatf("rnd.x%0d", i), if1.X, ex);
      chk($sformatf("rnd.y%0d", i), if1.Y, ey);
      @(posedge clk); #1;
    end
    chk("rnd.drain.done", 32'(if1.done), 32'h0);
    chk("rnd.drain.busy", 32'(if1.busy), 32'h1);
    @(posedge clk); #1;
    chk("rnd.done", 32'(if1.done), 32'h1);
    chk("rnd.busy", 32'(if1.busy), 32'h0);
    chk("rnd.pass", 32'(if1.pass), 32'h1);
    chk("rnd.err", 32'(if1.err_count), 32'h0);
    chk("rnd.ffi", 32'(if1.first_fail_idx), 32'hFFFF);

    // Reset in the middle of a failing run, then a clean run.
    mode = 1;
    @(negedge clk); if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset0("midrst");
    run0(0, 1'b0, 16'd0, 16'hFFFF, 1'b1);

    // start held high: no restart while busy, restart right after done.
    run0(1, 1'b1, 16'd4, 16'd1, 1'b0);
    @(posedge clk); #1;
    chk("restart.busy", 32'(if0.busy), 32'h1);
    chk("restart.done", 32'(if0.done), 32'h0);
    chk("restart.pass", 32'(if0.pass), 32'h0);
    chk("restart.err", 32'(if0.err_count), 32'h0);
    chk("restart.ffi", 32'(if0.first_fail_idx), 32'hFFFF);
    chk("restart.x", 32'(if0.X), 32'h0);
    chk("restart.y", 32'(if0.Y), 32'h0);
    mode = 0;
    if0.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("restart.end.done", 32'(if0.done), 32'h1);
    chk("restart.end.pass", 32'(if0.pass), 32'h1);
    chk("restart.end.err", 32'(if0.err_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
